// File: rtl/dmi_req_sequencer.sv
// DMI request sequencer: one outstanding DMI request forwarded to the debug module, response held until taken.
// Optional response timeout enabled by defining DMI_SEQ_TIMEOUT_EN.
module dmi_req_sequencer #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [40:0] dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [40:0] dm_req_o,
  output logic        dm_req_valid_o,
  input  logic        dm_req_ready_i,
  input  logic [33:0] dm_resp_i,
  input  logic        dm_resp_valid_i,
  output logic        dm_resp_ready_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [1:0]  OP_NOP   = 2'd0;
  localparam logic [1:0]  OP_READ  = 2'd1;
  localparam logic [1:0]  OP_WRITE = 2'd2;
  localparam logic [33:0] RESP_OK     = 34'd0;
  localparam logic [33:0] RESP_FAILED = 34'd2;

  state_e      state_q, state_d;
  logic [40:0] req_q, req_d;
  logic [33:0] resp_q, resp_d;
  logic        stale_q;
  logic        timeout;

`ifdef DMI_SEQ_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_d;

  // A response arriving on the expiry cycle wins over the synthesized failure.
  always_comb begin
    timeout = (state_q == WAIT) && !dm_resp_valid_i && (cnt_q == CntLast);
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (state_q == ISSUE && dm_req_ready_i) begin
      cnt_d = '0;
    end else if (state_q == WAIT && !dm_resp_valid_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout) begin
      stale_d = 1'b1;
    end else if (stale_q && dm_resp_valid_i) begin
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  assign stale_q = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (dmi_req_valid_i && !stale_q) begin
          req_d = dmi_req_i;
          unique case (dmi_req_i[1:0])
            OP_READ, OP_WRITE: state_d = ISSUE;
            OP_NOP: begin
              resp_d  = RESP_OK;
              state_d = RESP;
            end
            default: begin
              resp_d  = RESP_FAILED;
              state_d = RESP;
            end
          endcase
        end
      end
      ISSUE: begin
        if (dm_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (dm_resp_valid_i) begin
          resp_d  = dm_resp_i;
          state_d = RESP;
        end else if (timeout) begin
          resp_d  = RESP_FAILED;
          state_d = RESP;
        end
      end
      RESP: begin
        if (dmi_resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Handshake outputs decode state only; payloads come straight from registers.
  assign dmi_req_ready_o  = (state_q == IDLE) && !stale_q;
  assign dm_req_valid_o   = (state_q == ISSUE);
  assign dm_resp_ready_o  = (state_q == WAIT) || stale_q;
  assign dmi_resp_valid_o = (state_q == RESP);
  assign dm_req_o         = req_q;
  assign dmi_resp_o       = resp_q;

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Directed, table-driven bench for dmi_req_sequencer with hand-written reset and timeout sequences.
module tb_dmi_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [40:0] dmi_req_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [33:0] dmi_resp_o;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic [40:0] dm_req_o;
  logic        dm_req_valid_o;
  logic        dm_req_ready_i;
  logic [33:0] dm_resp_i;
  logic        dm_resp_valid_i;
  logic        dm_resp_ready_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmi_req_sequencer #(.TimeoutCycles(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .dmi_req_i        (dmi_req_i),
    .dmi_req_valid_i  (dmi_req_valid_i),
    .dmi_req_ready_o  (dmi_req_ready_o),
    .dmi_resp_o       (dmi_resp_o),
    .dmi_resp_valid_o (dmi_resp_valid_o),
    .dmi_resp_ready_i (dmi_resp_ready_i),
    .dm_req_o         (dm_req_o),
    .dm_req_valid_o   (dm_req_valid_o),
    .dm_req_ready_i   (dm_req_ready_i),
    .dm_resp_i        (dm_resp_i),
    .dm_resp_valid_i  (dm_resp_valid_i),
    .dm_resp_ready_o  (dm_resp_ready_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          rdy_dly;
    int          rsp_dly;
    logic [33:0] dm_resp;
    int          stall;
    logic [33:0] exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(dmi_req_ready_o), 64'd1);
    chk({tag, "_resp_valid"}, 64'(dmi_resp_valid_o), 64'd0);
    chk({tag, "_dm_req_valid"}, 64'(dm_req_valid_o), 64'd0);
    chk({tag, "_dm_resp_ready"}, 64'(dm_resp_ready_o), 64'd0);
    chk({tag, "_resp_data"}, 64'(dmi_resp_o), 64'd0);
    chk({tag, "_dm_req_data"}, 64'(dm_req_o), 64'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input vec_t v);
    logic [40:0] req;
    logic        is_dm;
    req   = {v.addr, v.data, v.op};
    is_dm = (v.op == 2'd1) || (v.op == 2'd2);
    dmi_req_i       = req;
    dmi_req_valid_i = 1'b1;
    chk("req_ready_idle", 64'(dmi_req_ready_o), 64'd1);
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    dmi_req_i       = '0;
    if (is_dm) begin
      for (int i = 0; i < v.rdy_dly; i++) begin
        chk("dm_req_valid_hold", 64'(dm_req_valid_o), 64'd1);
        chk("dm_req_payload", 64'(dm_req_o), 64'(req));
        chk("req_ready_busy", 64'(dmi_req_ready_o), 64'd0);
        @(negedge clk);
      end
      dm_req_ready_i = 1'b1;
      chk("dm_req_valid", 64'(dm_req_valid_o), 64'd1);
      chk("dm_req_payload", 64'(dm_req_o), 64'(req));
      @(negedge clk);
      dm_req_ready_i = 1'b0;
      chk("dm_req_dropped", 64'(dm_req_valid_o), 64'd0);
      for (int i = 0; i < v.rsp_dly; i++) begin
        chk("wait_resp_ready", 64'(dm_resp_ready_o), 64'd1);
        chk("wait_no_resp", 64'(dmi_resp_valid_o), 64'd0);
        chk("req_ready_busy", 64'(dmi_req_ready_o), 64'd0);
        @(negedge clk);
      end
      dm_resp_i       = v.dm_resp;
      dm_resp_valid_i = 1'b1;
      chk("wait_resp_ready", 64'(dm_resp_ready_o), 64'd1);
      @(negedge clk);
      dm_resp_valid_i = 1'b0;
      dm_resp_i       = '0;
    end else begin
      chk("no_dm_req", 64'(dm_req_valid_o), 64'd0);
    end
    for (int i = 0; i < v.stall; i++) begin
      dmi_req_i       = {7'h01, 32'h0, 2'd1};
      dmi_req_valid_i = 1'b1;
      chk("resp_valid_stall", 64'(dmi_resp_valid_o), 64'd1);
      chk("resp_data_stall", 64'(dmi_resp_o), 64'(v.exp_resp));
      chk("req_ready_stall", 64'(dmi_req_ready_o), 64'd0);
      chk("no_dm_req_stall", 64'(dm_req_valid_o), 64'd0);
      @(negedge clk);
    end
    dmi_req_valid_i  = 1'b0;
    dmi_req_i        = '0;
    dmi_resp_ready_i = 1'b1;
    chk("resp_valid", 64'(dmi_resp_valid_o), 64'd1);
    chk("resp_data", 64'(dmi_resp_o), 64'(v.exp_resp));
    @(negedge clk);
    dmi_resp_ready_i = 1'b0;
    chk("req_ready_after", 64'(dmi_req_ready_o), 64'd1);
    chk("resp_valid_after", 64'(dmi_resp_valid_o), 64'd0);
    $display("txn op=%0d addr=%h resp=%h errors=%0d", v.op, v.addr, v.exp_resp, errors);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{op: 2'd1, addr: 7'h11, data: 32'h0,  rdy_dly: 0, rsp_dly: 3,
                dm_resp: {32'hDEADBEEF, 2'd0}, stall: 0, exp_resp: {32'hDEADBEEF, 2'd0}};
    vecs[1] = '{op: 2'd2, addr: 7'h04, data: 32'h1,  rdy_dly: 5, rsp_dly: 0,
                dm_resp: {32'h0, 2'd0}, stall: 0, exp_resp: {32'h0, 2'd0}};
    vecs[2] = '{op: 2'd0, addr: 7'h03, data: 32'h1234, rdy_dly: 0, rsp_dly: 0,
                dm_resp: 34'd0, stall: 0, exp_resp: {32'h0, 2'd0}};
    vecs[3] = '{op: 2'd3, addr: 7'h10, data: 32'hFFFF, rdy_dly: 0, rsp_dly: 0,
                dm_resp: 34'd0, stall: 0, exp_resp: {32'h0, 2'd2}};
    vecs[4] = '{op: 2'd1, addr: 7'h7F, data: 32'h0,  rdy_dly: 1, rsp_dly: 1,
                dm_resp: {32'h12345678, 2'd2}, stall: 10, exp_resp: {32'h12345678, 2'd2}};
    vecs[5] = '{op: 2'd0, addr: 7'h00, data: 32'h0,  rdy_dly: 0, rsp_dly: 0,
                dm_resp: 34'd0, stall: 10, exp_resp: {32'h0, 2'd0}};

    rst_i = 1'b1;
    dmi_req_i = '0; dmi_req_valid_i = 1'b0; dmi_resp_ready_i = 1'b0;
    dm_req_ready_i = 1'b0; dm_resp_i = '0; dm_resp_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset while waiting for the debug module; the in-flight response is lost.
    dmi_req_i = {7'h22, 32'h0, 2'd1};
    dmi_req_valid_i = 1'b1;
    dm_req_ready_i  = 1'b1;
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    @(negedge clk);
    dm_req_ready_i = 1'b0;
    chk("rst_wait_entered", 64'(dm_resp_ready_o), 64'd1);
    rst_i           = 1'b1;
    dm_resp_valid_i = 1'b1;
    dm_resp_i       = {32'h55AA55AA, 2'd0};
    @(negedge clk);
    rst_i           = 1'b0;
    dm_resp_valid_i = 1'b0;
    dm_resp_i       = '0;
    chk_reset_outputs("rst_in_wait");
    @(negedge clk);
    chk("rst_resp_lost", 64'(dmi_resp_valid_o), 64'd0);
    run_txn(vecs[0]);

`ifdef DMI_SEQ_TIMEOUT_EN
    // Debug module never answers: failed response after 8 WAIT cycles, then a late beat is dropped.
    dmi_req_i = {7'h33, 32'h0, 2'd1};
    dmi_req_valid_i = 1'b1;
    dm_req_ready_i  = 1'b1;
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    @(negedge clk);
    dm_req_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_no_resp", 64'(dmi_resp_valid_o), 64'd0);
      chk("to_wait_resp_ready", 64'(dm_resp_ready_o), 64'd1);
      @(negedge clk);
    end
    chk("to_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
    chk("to_resp_data", 64'(dmi_resp_o), 64'({32'h0, 2'd2}));
    dmi_resp_ready_i = 1'b1;
    @(negedge clk);
    dmi_resp_ready_i = 1'b0;
    dmi_req_i = {7'h11, 32'h0, 2'd1};
    dmi_req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stale_req_blocked", 64'(dmi_req_ready_o), 64'd0);
      chk("stale_resp_ready", 64'(dm_resp_ready_o), 64'd1);
      chk("stale_no_dm_req", 64'(dm_req_valid_o), 64'd0);
      @(negedge clk);
    end
    dm_resp_valid_i = 1'b1;
    dm_resp_i       = {32'hBAD0BAD0, 2'd0};
    @(negedge clk);
    dm_resp_valid_i = 1'b0;
    dm_resp_i       = '0;
    dmi_req_valid_i = 1'b0;
    dmi_req_i       = '0;
    chk("stale_cleared_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("stale_cleared_resp_ready", 64'(dm_resp_ready_o), 64'd0);
    chk("late_resp_dropped", 64'(dmi_resp_valid_o), 64'd0);
    v = '{op: 2'd1, addr: 7'h11, data: 32'h0, rdy_dly: 0, rsp_dly: 2,
          dm_resp: {32'hCAFEF00D, 2'd0}, stall: 0, exp_resp: {32'hCAFEF00D, 2'd0}};
    run_txn(v);
`else
    // Without the timeout, WAIT holds well past the would-be expiry.
    v = '{op: 2'd1, addr: 7'h2A, data: 32'h0, rdy_dly: 0, rsp_dly: 20,
          dm_resp: {32'hCAFEF00D, 2'd0}, stall: 0, exp_resp: {32'hCAFEF00D, 2'd0}};
    run_txn(v);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
